piso_serializer_ctrl: RTL and testbench

//   Sequencer for a parallel-in/serial-out shift register. Accepts parallel words on a

---
 rtl/serializer_pkg.sv | 12 +
 rtl/piso_shift_reg.sv | 38 +++
 rtl/piso_serializer_ctrl.sv | 87 ++++++++
 tb/tb_piso_serializer_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared definitions for the PISO serializer: state encoding and counter sizing.
package serializer_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Bit-counter width for a word of the given width; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// WIDTH-bit parallel-load shift register with zero fill; load wins over shift.
module piso_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  input  logic             msb_first,
  output logic             q_bit
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // Next register contents: load, else shift toward the transmitted end, else hold.
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = d;
    end else if (shift_en) begin
      shreg_d = msb_first ? (shreg_q << 1) : (shreg_q >> 1);
    end
  end

  // Register storage, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign q_bit = msb_first ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: rtl/piso_serializer_ctrl.sv
// Parallel-in/serial-out sequencer: takes words on a valid/ready port and emits
// them one bit per accepted beat, chaining words back-to-back with no bubble.
module piso_serializer_ctrl
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic             busy
);

  localparam int             CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic             state_q;
  logic             state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cnt_last;
  logic             bit_acc;
  logic             load;
  logic             shift_en;
  logic             q_bit;

  assign cnt_last = (cnt_q == CNT_LAST);
  assign bit_acc  = ser_valid & ser_ready;
  assign load     = in_valid & in_ready;
  assign shift_en = bit_acc;

  // State and bit-counter registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and counter: a new word restarts the count, the last bit wraps it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_SHIFT;
      ST_SHIFT: if (bit_acc && cnt_last && !in_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (load) begin
      cnt_d = '0;
    end else if (bit_acc) begin
      cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Outputs; in_ready also opens on an accepted last bit so the next word chains in.
  always_comb begin
    busy      = (state_q == ST_SHIFT);
    ser_valid = busy;
    ser_last  = busy & cnt_last;
    ser_out   = busy & q_bit;
    in_ready  = ~busy | (ser_last & ser_ready);
  end

  piso_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift_en (shift_en),
    .d        (in_data),
    .msb_first(MSB_FIRST != 0),
    .q_bit    (q_bit)
  );

endmodule

// File: tb/tb_piso_serializer_ctrl.sv
// Directed bench for piso_serializer_ctrl: one MSB-first and one LSB-first instance.
`timescale 1ns/100ps
module tb_piso_serializer_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_data,   in_data_b;
  logic             in_valid,  in_valid_b;
  logic             ser_ready, ser_ready_b;
  logic             in_ready,  in_ready_b;
  logic             ser_out,   ser_out_b;
  logic             ser_valid, ser_valid_b;
  logic             ser_last,  ser_last_b;
  logic             busy,      busy_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  piso_serializer_ctrl #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .ser_last(ser_last), .ser_ready(ser_ready), .busy(busy)
  );

  piso_serializer_ctrl #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .ser_out(ser_out_b), .ser_valid(ser_valid_b),
    .ser_last(ser_last_b), .ser_ready(ser_ready_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk_a(input string tag, input logic e_out, input logic e_vld,
                       input logic e_last, input logic e_busy, input logic e_rdy);
    check({tag, ".ser_out"},   ser_out,   e_out);
    check({tag, ".ser_valid"}, ser_valid, e_vld);
    check({tag, ".ser_last"},  ser_last,  e_last);
    check({tag, ".busy"},      busy,      e_busy);
    check({tag, ".in_ready"},  in_ready,  e_rdy);
  endtask

  task automatic chk_b(input string tag, input logic e_out, input logic e_vld,
                       input logic e_last, input logic e_busy, input logic e_rdy);
    check({tag, ".ser_out"},   ser_out_b,   e_out);
    check({tag, ".ser_valid"}, ser_valid_b, e_vld);
    check({tag, ".ser_last"},  ser_last_b,  e_last);
    check({tag, ".busy"},      busy_b,      e_busy);
    check({tag, ".in_ready"},  in_ready_b,  e_rdy);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    ser_ready   = 1'b0;
    in_data_b   = '0;
    in_valid_b  = 1'b0;
    ser_ready_b = 1'b0;

    // Reset held 12 ns, then released between edges
    #12 reset = 1'b1;
    #1;
    chk_a("t1_reset", 0, 0, 0, 0, 1);
    chk_b("t1_reset_lsb", 0, 0, 0, 0, 1);

    // Single word 1010, consumer always ready
    in_data = 4'b1010; in_valid = 1'b1; ser_ready = 1'b1;
    tick(); chk_a("t2_b0", 1, 1, 0, 1, 0); in_valid = 1'b0;
    tick(); chk_a("t2_b1", 0, 1, 0, 1, 0);
    tick(); chk_a("t2_b2", 1, 1, 0, 1, 0);
    tick(); chk_a("t2_b3", 0, 1, 1, 1, 1);
    tick(); chk_a("t2_idle", 0, 0, 0, 0, 1);

    // Back-to-back 1010 then 1111 with in_valid held
    in_data = 4'b1010; in_valid = 1'b1;
    tick(); chk_a("t3_b0", 1, 1, 0, 1, 0); in_data = 4'b1111;
    tick(); chk_a("t3_b1", 0, 1, 0, 1, 0);
    tick(); chk_a("t3_b2", 1, 1, 0, 1, 0);
    tick(); chk_a("t3_b3", 0, 1, 1, 1, 1);
    tick(); chk_a("t3_b4", 1, 1, 0, 1, 0); in_valid = 1'b0;
    tick(); chk_a("t3_b5", 1, 1, 0, 1, 0);
    tick(); chk_a("t3_b6", 1, 1, 0, 1, 0);
    tick(); chk_a("t3_b7", 1, 1, 1, 1, 1);
    tick(); chk_a("t3_idle", 0, 0, 0, 0, 1);

    // 0110 with a three-cycle consumer stall on the second bit
    in_data = 4'b0110; in_valid = 1'b1; ser_ready = 1'b1;
    tick(); chk_a("t4_b0", 0, 1, 0, 1, 0); in_valid = 1'b0;
    tick(); chk_a("t4_b1", 1, 1, 0, 1, 0); ser_ready = 1'b0;
    tick(); chk_a("t4_stall0", 1, 1, 0, 1, 0);
    tick(); chk_a("t4_stall1", 1, 1, 0, 1, 0);
    tick(); chk_a("t4_stall2", 1, 1, 0, 1, 0); ser_ready = 1'b1;
    tick(); chk_a("t4_b2", 1, 1, 0, 1, 0);
    tick(); chk_a("t4_b3", 0, 1, 1, 1, 1);
    tick(); chk_a("t4_idle", 0, 0, 0, 0, 1);

    // 1101 interrupted by an asynchronous reset after two bits
    in_data = 4'b1101; in_valid = 1'b1;
    tick(); chk_a("t5_b0", 1, 1, 0, 1, 0); in_valid = 1'b0;
    tick(); chk_a("t5_b1", 1, 1, 0, 1, 0);
    tick(); chk_a("t5_b2", 0, 1, 0, 1, 0);
    #2 reset = 1'b0;
    #1;
    check("t5_async.ser_valid", ser_valid, 1'b0);
    check("t5_async.busy",      busy,      1'b0);
    check("t5_async.ser_out",   ser_out,   1'b0);
    check("t5_async.ser_last",  ser_last,  1'b0);
    tick();
    check("t5_held.ser_valid", ser_valid, 1'b0);
    reset = 1'b1;
    tick(); chk_a("t5_after", 0, 0, 0, 0, 1);
    in_data = 4'b0101; in_valid = 1'b1;
    tick(); chk_a("t5_n0", 0, 1, 0, 1, 0); in_valid = 1'b0;
    tick(); chk_a("t5_n1", 1, 1, 0, 1, 0);
    tick(); chk_a("t5_n2", 0, 1, 0, 1, 0);
    tick(); chk_a("t5_n3", 1, 1, 1, 1, 1);
    tick(); chk_a("t5_idle", 0, 0, 0, 0, 1);

    // LSB-first instance: 1101 goes out as 1,0,1,1
    in_data_b = 4'b1101; in_valid_b = 1'b1; ser_ready_b = 1'b1;
    tick(); chk_b("t6_b0", 1, 1, 0, 1, 0); in_valid_b = 1'b0;
    tick(); chk_b("t6_b1", 0, 1, 0, 1, 0);
    tick(); chk_b("t6_b2", 1, 1, 0, 1, 0);
    tick(); chk_b("t6_b3", 1, 1, 1, 1, 1);
    tick(); chk_b("t6_idle", 0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
